// File: rtl/mac_adder_tree.sv
// mac_adder_tree: pipelined signed adder tree that reduces N_IN masked MAC lanes to one sum per cycle.
// Optional macro MAC_ADDER_TREE_SAT_EN: saturate the root sum to WID bits instead of wrapping.
module mac_adder_tree #(
    parameter int N_IN = 32,
    parameter int WID  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [WID-1:0] output_mac [N_IN-1:0],
    input  logic [N_IN-1:0]       mac_enable,
    input  logic                  adder_enable,
    output logic signed [WID-1:0] adder_tree_out,
    output logic                  adder_tree_vld
);
    localparam int LAT = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int P   = 1 << LAT;
    localparam int WL  = WID + LAT;
`ifdef MAC_ADDER_TREE_SAT_EN
    localparam logic signed [WL-1:0] SMAX = {{(LAT+1){1'b0}}, {(WID-1){1'b1}}};
    localparam logic signed [WL-1:0] SMIN = {{(LAT+1){1'b1}}, {(WID-1){1'b0}}};
`endif
    logic signed [WL-1:0]  leaf   [P-1:0];
    logic signed [WL-1:0]  node_d [P-1:1];
    logic signed [WL-1:0]  node_q [P-1:1];
    logic [LAT-1:0]        vld_d, vld_q;
    logic signed [WID-1:0] out_d, out_q;

    for (genvar j = 0; j < P; j++) begin : g_leaf
        if (j < N_IN) begin : g_lane
            assign leaf[j] = mac_enable[j] ? WL'(output_mac[j]) : '0;
        end else begin : g_pad
            assign leaf[j] = '0;
        end
    end

    for (genvar i = 1; i < P; i++) begin : g_node
        if (2 * i >= P) begin : g_bot
            assign node_d[i] = leaf[2*i-P] + leaf[2*i+1-P];
        end else begin : g_mid
            assign node_d[i] = node_q[2*i] + node_q[2*i+1];
        end
    end

    // Valid shift and root narrowing; the output only changes when a valid reaches the root.
    always_comb begin
        vld_d = (vld_q << 1) | LAT'(adder_enable);
`ifdef MAC_ADDER_TREE_SAT_EN
        out_d = !vld_d[LAT-1] ? out_q :
                (node_d[1] > SMAX) ? SMAX[WID-1:0] :
                (node_d[1] < SMIN) ? SMIN[WID-1:0] : node_d[1][WID-1:0];
`else
        out_d = vld_d[LAT-1] ? node_d[1][WID-1:0] : out_q;
`endif
    end

    // Tree levels load every clock; reset discards all in-flight sums and valids.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 2; i < P; i++) node_q[i] <= '0;
            vld_q <= '0;
            out_q <= '0;
        end else begin
            for (int i = 2; i < P; i++) node_q[i] <= node_d[i];
            vld_q <= vld_d;
            out_q <= out_d;
        end
    end

    assign adder_tree_out = out_q;
    assign adder_tree_vld = vld_q[LAT-1];
endmodule

// File: tb/tb_mac_adder_tree.sv
// tb_mac_adder_tree: randomized check of mac_adder_tree against a sum-of-lanes reference model.
module tb_mac_adder_tree;
    localparam int N = 32, W = 16, LAT = 5;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic signed [W-1:0] mac [N-1:0];
    logic [N-1:0] me = '0;
    logic signed [W-1:0] out;
    logic vld;
    int n_cmp = 0, n_bad = 0, cyc = 0;
    bit due [0:1023];
    logic [W-1:0] due_val [0:1023];
    logic [W-1:0] exp_out = '0;

    mac_adder_tree #(.N_IN(N), .WID(W)) dut (
        .clk(clk), .rst(rst), .output_mac(mac), .mac_enable(me),
        .adder_enable(en), .adder_tree_out(out), .adder_tree_vld(vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_sum();
        longint s = 0;
        for (int i = 0; i < N; i++) if (me[i]) s += longint'(mac[i]);
`ifdef MAC_ADDER_TREE_SAT_EN
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
`endif
        return s[W-1:0];
    endfunction

    task automatic tick();
        if (!rst && en) begin
            due[cyc+LAT] = 1'b1;
            due_val[cyc+LAT] = ref_sum();
        end
        @(posedge clk);
        cyc++;
        #1;
        if (due[cyc]) exp_out = due_val[cyc];
        chk("vld", W'(vld), W'(due[cyc]));
        chk("out", out, exp_out);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic set_all(input logic [W-1:0] v, input logic [N-1:0] m, input logic e);
        for (int i = 0; i < N; i++) mac[i] = v;
        me = m;
        en = e;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        for (int i = 0; i < 1024; i++) due[i] = 1'b0;
        exp_out = '0;
        chk("rst_out", out, '0);
        chk("rst_vld", W'(vld), '0);
        en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        set_all('0, '0, 1'b0);
        tick();
        chk("reset_out", out, '0);
        rst = 1'b0;
        ticks(2);
        set_all(16'd1, '1, 1'b1);
        tick();
        en = 1'b0;
        ticks(LAT + 1);
        chk("basic", out, 16'd32);
        set_all(16'd100, '1, 1'b1);
        mac[0] = -16'sd7;
        me = 32'h0000_0001;
        tick();
        en = 1'b0;
        ticks(LAT + 1);
        chk("mask", out, 16'hFFF9);
        set_all(16'd1, '1, 1'b1); tick();
        set_all(16'd2, '1, 1'b1); tick();
        set_all(16'd3, '1, 1'b1); tick();
        set_all(-16'sd4, '1, 1'b1); tick();
        set_all(16'd9, '1, 1'b0);
        ticks(LAT + 4);
        chk("stream_hold", out, 16'hFF80);
        set_all(16'd50, '0, 1'b1);
        tick();
        set_all(16'd50, '1, 1'b0);
        ticks(LAT + 2);
        chk("zero_mask", out, '0);
        set_all(16'h7FFF, '1, 1'b1);
        tick();
        en = 1'b0;
        ticks(LAT + 1);
`ifdef MAC_ADDER_TREE_SAT_EN
        chk("overflow", out, 16'h7FFF);
`else
        chk("overflow", out, 16'hFFE0);
`endif
        do_reset();
        ticks(2);
        set_all(16'd5, '1, 1'b1);
        tick();
        en = 1'b0;
        ticks(2);
        do_reset();
        ticks(10);
        chk("flight_out", out, '0);
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < N; i++)
                mac[i] = k[0] ? W'($urandom) : W'(int'($urandom_range(0, 400)) - 200);
            me = $urandom;
            if ($urandom_range(0, 7) == 0) me = '0;
            en = $urandom_range(0, 9) < 6;
            tick();
        end
        en = 1'b0;
        ticks(LAT + 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
